// File: rtl/ldpc_phase_sequencer.sv
// Phase sequencer for an iterative LDPC decoder: walks each codeword through
// LOAD, DECODE iterations and UNLOAD, with syndrome-based early termination.
module ldpc_phase_sequencer #(
    parameter int LOG2N = 4,
    parameter int N     = 12,
    parameter int LOG2I = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LOG2I-1:0] max_iter,
    input  logic             in_valid,
    input  logic             syndrome_ok,
    input  logic             out_ready,
    output logic [LOG2N-1:0] data_iter_count,
    output logic [LOG2I-1:0] iter_count,
    output logic [3:0]       state,
    output logic             in_ready,
    output logic             out_valid,
    output logic             done,
    output logic             early_term
);

    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        LOAD   = 4'b0010,
        DECODE = 4'b0100,
        UNLOAD = 4'b1000
    } state_t;

    localparam logic [LOG2N-1:0] LAST_BEAT = LOG2N'(N - 1);

    state_t           cur_state;
    logic [LOG2I-1:0] limit;
    logic [LOG2I:0]   iter_inc;

    // One-wider sum so the limit compare stays correct when iter_count is saturated.
    assign iter_inc  = {1'b0, iter_count} + (LOG2I + 1)'(1);

    assign state     = cur_state;
    assign in_ready  = (cur_state == LOAD);
    assign out_valid = (cur_state == UNLOAD);

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state       <= IDLE;
            data_iter_count <= '0;
            iter_count      <= '0;
            limit           <= LOG2I'(1);
            done            <= 1'b0;
            early_term      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (cur_state)
                IDLE: begin
                    if (start) begin
                        limit           <= (max_iter == '0) ? LOG2I'(1) : max_iter;
                        iter_count      <= '0;
                        early_term      <= 1'b0;
                        data_iter_count <= '0;
                        cur_state       <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        if (data_iter_count == LAST_BEAT) begin
                            data_iter_count <= '0;
                            cur_state       <= DECODE;
                        end else begin
                            data_iter_count <= data_iter_count + LOG2N'(1);
                        end
                    end
                end
                DECODE: begin
                    if (data_iter_count == LAST_BEAT) begin
                        data_iter_count <= '0;
                        if (iter_count != '1)
                            iter_count <= iter_count + LOG2I'(1);
                        if (syndrome_ok) begin
                            early_term <= 1'b1;
                            cur_state  <= UNLOAD;
                        end else if (iter_inc >= {1'b0, limit}) begin
                            cur_state  <= UNLOAD;
                        end
                    end else begin
                        data_iter_count <= data_iter_count + LOG2N'(1);
                    end
                end
                UNLOAD: begin
                    if (out_ready) begin
                        if (data_iter_count == LAST_BEAT) begin
                            data_iter_count <= '0;
                            done            <= 1'b1;
                            cur_state       <= IDLE;
                        end else begin
                            data_iter_count <= data_iter_count + LOG2N'(1);
                        end
                    end
                end
                default: begin
                    cur_state       <= IDLE;
                    data_iter_count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ldpc_phase_sequencer.sv
// Self-checking bench for ldpc_phase_sequencer: scenario table, hand-written
// corner sequences and randomized traffic against a phase-level model.
module tb_ldpc_phase_sequencer;

    localparam int LOG2N = 4;
    localparam int N     = 12;
    localparam int LOG2I = 5;
    localparam int IMAX  = (1 << LOG2I) - 1;

    logic             clk = 1'b0;
    logic             rst, start, in_valid, syndrome_ok, out_ready;
    logic [LOG2I-1:0] max_iter;
    logic [LOG2N-1:0] data_iter_count;
    logic [LOG2I-1:0] iter_count;
    logic [3:0]       state;
    logic             in_ready, out_valid, done, early_term;

    ldpc_phase_sequencer #(.LOG2N(LOG2N), .N(N), .LOG2I(LOG2I)) dut (
        .clk(clk), .rst(rst), .start(start), .max_iter(max_iter),
        .in_valid(in_valid), .syndrome_ok(syndrome_ok), .out_ready(out_ready),
        .data_iter_count(data_iter_count), .iter_count(iter_count),
        .state(state), .in_ready(in_ready), .out_valid(out_valid),
        .done(done), .early_term(early_term)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: phase index 0..3 = idle, load, decode, unload.
    int m_phase, m_beat, m_iters, m_limit, m_et, m_done;

    task automatic chk(input string name, input int actual, input int expected);
        n_chk++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic model_step(input bit r, s, input int mi, input bit iv, so, ordy);
        if (r) begin
            m_phase = 0; m_beat = 0; m_iters = 0; m_limit = 1; m_et = 0; m_done = 0;
            return;
        end
        m_done = 0;
        case (m_phase)
            0: if (s) begin
                m_limit = (mi == 0) ? 1 : mi;
                m_iters = 0; m_et = 0; m_beat = 0; m_phase = 1;
            end
            1: if (iv) begin
                if (m_beat == N - 1) begin m_beat = 0; m_phase = 2; end
                else m_beat++;
            end
            2: begin
                if (m_beat == N - 1) begin
                    m_beat  = 0;
                    m_iters = (m_iters + 1 > IMAX) ? IMAX : m_iters + 1;
                    if (so) begin m_et = 1; m_phase = 3; end
                    else if (m_iters >= m_limit) m_phase = 3;
                end else m_beat++;
            end
            default: if (ordy) begin
                if (m_beat == N - 1) begin m_beat = 0; m_phase = 0; m_done = 1; end
                else m_beat++;
            end
        endcase
    endtask

    task automatic check_all();
        chk("state",           int'(state),           1 << m_phase);
        chk("data_iter_count", int'(data_iter_count), m_beat);
        chk("iter_count",      int'(iter_count),      m_iters);
        chk("in_ready",        int'(in_ready),        int'(m_phase == 1));
        chk("out_valid",       int'(out_valid),       int'(m_phase == 3));
        chk("done",            int'(done),            m_done);
        chk("early_term",      int'(early_term),      m_et);
    endtask

    task automatic cycle(input bit r, s, input int mi, input bit iv, so, ordy);
        rst = r; start = s; max_iter = LOG2I'(mi);
        in_valid = iv; syndrome_ok = so; out_ready = ordy;
        model_step(r, s, mi, iv, so, ordy);
        @(posedge clk);
        #1;
        check_all();
    endtask

    typedef struct {
        int mi;        // max_iter presented at start
        int syn_iter;  // iteration (1-based) whose last beat sees syndrome_ok, 0 = never
        bit tog;       // in_valid/out_ready toggle 0,1,0,1 from phase entry
        bit sp;        // pulse start (with another max_iter) during DECODE
        int e_load, e_dec, e_unl, e_iter, e_et;
    } scn_t;

    scn_t scn[6];

    task automatic run_scn(input scn_t t, input int idx);
        int ld = 0, dc = 0, ul = 0, cyc = 0, ph = 0;
        bit fin = 0, iv, so, ordy, sp;
        logic [3:0] cur;
        cycle(0, 1, t.mi, 1, 0, 1);
        while (!fin && cyc < 3000) begin
            cur = state;
            case (cur)
                4'b0010: ld++;
                4'b0100: dc++;
                4'b1000: ul++;
                default: ;
            endcase
            iv   = t.tog ? ph[0] : 1'b1;
            ordy = t.tog ? ph[0] : 1'b1;
            so   = (m_phase == 2 && m_beat == N - 1 && m_iters + 1 == t.syn_iter);
            sp   = t.sp && (cur == 4'b0100);
            cycle(0, sp, sp ? IMAX : t.mi, iv, so, ordy);
            ph = (state != cur) ? 0 : ph + 1;
            if (done) fin = 1;
            cyc++;
        end
        chk($sformatf("scn%0d_finished", idx), int'(fin), 1);
        chk($sformatf("scn%0d_load_cycles", idx), ld, t.e_load);
        chk($sformatf("scn%0d_decode_cycles", idx), dc, t.e_dec);
        chk($sformatf("scn%0d_unload_cycles", idx), ul, t.e_unl);
        chk($sformatf("scn%0d_iter_count", idx), int'(iter_count), t.e_iter);
        chk($sformatf("scn%0d_early_term", idx), int'(early_term), t.e_et);
    endtask

    initial begin
        int k;
        bit hit;
        scn[0] = '{3,  0, 0, 0, 12, 36,  12, 3,  0};
        scn[1] = '{10, 2, 0, 0, 12, 24,  12, 2,  1};
        scn[2] = '{3,  0, 1, 0, 24, 36,  24, 3,  0};
        scn[3] = '{0,  0, 0, 1, 12, 12,  12, 1,  0};
        scn[4] = '{3,  3, 0, 0, 12, 36,  12, 3,  1};
        scn[5] = '{31, 0, 0, 0, 12, 372, 12, 31, 0};

        // Reset from an unknown state, then check the reset values explicitly.
        cycle(1, 1, 7, 1, 1, 1);
        cycle(1, 0, 0, 0, 0, 0);
        chk("reset_state", int'(state), 1);
        chk("reset_count", int'(data_iter_count), 0);
        chk("reset_in_ready", int'(in_ready), 0);
        cycle(0, 0, 0, 1, 1, 1);
        chk("idle_holds", int'(state), 1);

        for (int i = 0; i < 6; i++) run_scn(scn[i], i);

        // Reset in the middle of the second decode iteration.
        cycle(0, 1, 3, 1, 0, 1);
        k = 0; hit = 0;
        while (!hit && k < 200) begin
            cycle(0, 0, 3, 1, 0, 1);
            hit = (m_phase == 2 && m_iters == 1 && m_beat == 5);
            k++;
        end
        chk("mid_decode_reached", int'(hit), 1);
        chk("mid_decode_iter", int'(iter_count), 1);
        chk("mid_decode_beat", int'(data_iter_count), 5);
        cycle(1, 1, 3, 1, 1, 1);
        chk("midrst_state", int'(state), 1);
        chk("midrst_count", int'(data_iter_count), 0);
        chk("midrst_iter", int'(iter_count), 0);
        chk("midrst_done", int'(done), 0);
        run_scn(scn[0], 6);

        // start held high across done: first codeword terminates early.
        cycle(0, 1, 3, 1, 0, 1);
        k = 0;
        while (!done && k < 200) begin
            cycle(0, 1, 3, 1, (m_phase == 2 && m_beat == N - 1), 1);
            k++;
        end
        chk("held_done_seen", int'(done), 1);
        chk("held_done_idle", int'(state), 1);
        chk("held_et_first", int'(early_term), 1);
        cycle(0, 1, 0, 1, 0, 1);
        chk("held_restart_load", int'(state), 2);
        chk("held_restart_iter", int'(iter_count), 0);
        chk("held_restart_et", int'(early_term), 0);
        chk("held_restart_done", int'(done), 0);
        k = 0;
        while (!done && k < 200) begin
            cycle(0, 0, 0, 1, 0, 1);
            k++;
        end
        chk("held_second_done", int'(done), 1);
        chk("held_second_iter", int'(iter_count), 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 5000; i++) begin
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0,
                  int'($urandom_range(0, 4)), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
